// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline stage -- registered ALU/link writeback plus a stalling
// IDLE/ACCESS data-memory handshake. Define MEM_WB_TIMEOUT_EN to abort accesses after MAX_WAIT cycles.
`timescale 1ns/1ps
module mem_wb #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic [1:0]  ex_result_src,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc_plus_4,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        writeback_control,
  output logic [4:0]  rd,
  output logic [31:0] writeback_data,
  output logic        mem_err
);

  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Context of the in-flight access needed to retire a load.
  typedef struct packed {
    logic       wb_en;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] lane;
  } pend_t;

  state_e      r_state;
  state_e      w_state_next;
  pend_t       r_pend;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wb_en;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;
  logic        r_mem_err;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_timeout;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("mem_wb: MAX_WAIT must lie in 1..255");
  end

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   store_strobe = 4'b0001 << lane;
      2'b01:   store_strobe = 4'b0011 << lane;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  assign w_accept     = ex_valid && (r_state == IDLE);
  assign w_is_mem     = (ex_result_src == SRC_LOAD) || ex_memwrite;
  assign w_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                        ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));

`ifdef MEM_WB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  logic [7:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_wait_cnt <= '0;
    end else if (!dmem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == ACCESS) && !dmem_ready && (r_wait_cnt == WAIT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem && !w_misaligned) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ready || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wb_en   <= 1'b0;
      r_rd      <= '0;
      r_wb_data <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_wb_en   <= 1'b0;
      r_mem_err <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept && !w_is_mem) begin
          r_wb_en   <= ex_regwrite && (ex_rd != 5'd0);
          r_rd      <= ex_rd;
          r_wb_data <= (ex_result_src == SRC_LINK) ? ex_pc_plus_4 : ex_alu_result;
        end else if (w_accept && w_misaligned) begin
          r_mem_err <= 1'b1;
        end else if (w_accept) begin
          r_we          <= ex_memwrite;
          r_addr        <= {ex_alu_result[31:2], 2'b00};
          r_wdata       <= store_lanes(ex_funct3[1:0], ex_write_data);
          r_wstrb       <= store_strobe(ex_funct3[1:0], ex_alu_result[1:0]);
          r_pend.wb_en  <= ex_regwrite && (ex_rd != 5'd0) && !ex_memwrite;
          r_pend.rd     <= ex_rd;
          r_pend.funct3 <= ex_funct3;
          r_pend.lane   <= ex_alu_result[1:0];
        end
      end else if (dmem_ready) begin
        // Retirement lands in the cycle stall_m drops.
        r_wb_en <= r_pend.wb_en;
        if (r_pend.wb_en) begin
          r_rd      <= r_pend.rd;
          r_wb_data <= load_extend(dmem_rdata, r_pend.funct3, r_pend.lane);
        end
      end else if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign stall_m           = (r_state == ACCESS);
  assign dmem_req          = (r_state == ACCESS);
  assign dmem_we           = r_we;
  assign dmem_addr         = r_addr;
  assign dmem_wdata        = r_wdata;
  assign dmem_wstrb        = r_wstrb;
  assign writeback_control = r_wb_en;
  assign rd                = r_rd;
  assign writeback_data    = r_wb_data;
  assign mem_err           = r_mem_err;

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 15, cycles a data-memory access may wait before timeout (range 1..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, all state on rising edge
 reset_n  in  1  asynchronous active-low reset
 ex_valid  in  1  EX stage presents an instruction
 ex_alu_result  in  32  ALU result / memory address
 ex_write_data  in  32  store data (rs2)
 ex_rd  in  5  destination register
 ex_regwrite  in  1  instruction writes rd
 ex_result_src  in  2  00 ALU, 01 load, 10 pc_plus_4, 11 reserved (treated as ALU)
 ex_memwrite  in  1  store instruction
 ex_funct3  in  3  load/store size and sign
 ex_pc_plus_4  in  32  link value
 stall_m  out  1  upstream must hold ex_* stable
 dmem_req  out  1  memory request valid
 dmem_we  out  1  1 store, 0 load
 dmem_addr  out  32  word-aligned address ({ex_alu_result[31:2],2'b00})
 dmem_wdata  out  32  lane-replicated store data
 dmem_wstrb  out  4  byte enables
 dmem_ready  in  1  memory completes access this cycle
 dmem_rdata  in  32  load word, valid with dmem_ready
 writeback_control  out  1  register-file write enable (to decode stage)
 rd  out  5  register-file write index
 writeback_data  out  32  register-file write data
 mem_err  out  1  one-cycle pulse: misaligned access or timeout

Function
REQ-003 SHALL accept an instruction on a rising edge where ex_valid=1 and stall_m=0.
REQ-004 SHALL define memory op as ex_result_src=01 or ex_memwrite=1; all others are non-memory.
REQ-005 Non-memory op: writeback_control/rd/writeback_data SHALL be registered, valid the cycle after acceptance (latency 1); data = ex_alu_result, or ex_pc_plus_4 when ex_result_src=10.
REQ-006 FSM states IDLE, ACCESS; aligned memory op accepted in IDLE -> ACCESS; stall_m = (state==ACCESS), combinational.
REQ-007 In ACCESS, dmem_req=1 with dmem_we/addr/wdata/wstrb held constant from captured values until dmem_ready sampled 1; dmem_req=0 in IDLE.
REQ-008 On dmem_ready=1 in ACCESS: next state IDLE; load writeback SHALL appear in the same cycle stall_m falls (one cycle after ready).
REQ-009 Load extension by funct3 on lane ex_alu_result[1:0]: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; other codes return full word.
REQ-010 Stores: 000 SB wstrb=0001<<addr[1:0], wdata byte x4; 001 SH wstrb=0011<<addr[1:0], wdata halfword x2; 010 SW wstrb=1111.
REQ-011 Misaligned (halfword addr[0]=1, word addr[1:0]!=00): no dmem_req, stay IDLE, writeback suppressed, mem_err pulse next cycle.
REQ-012 writeback_control SHALL be a one-cycle pulse per retired instruction, 0 when ex_regwrite=0, rd=0, store, or aborted access.
REQ-013 ex_valid=0 in IDLE SHALL produce writeback_control=0 next cycle.
REQ-014 dmem_ready asserted while IDLE SHALL be ignored.

Reset
REQ-015 reset_n=0 SHALL immediately force state IDLE, dmem_req=0, stall_m=0, writeback_control=0, mem_err=0, rd=0, writeback_data=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, wait counter=0.
REQ-016 Reset during ACCESS SHALL abandon the access with no writeback after reset release.

Configuration
REQ-017 Macro MEM_WB_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle without dmem_ready; on reaching MAX_WAIT, return IDLE, drop dmem_req, suppress writeback, pulse mem_err.
REQ-018 Macro undefined: no counter; ACCESS waits indefinitely; mem_err only for misalignment.

Verification
REQ-019 ADD result 0x0000_0042, rd=5, regwrite=1 -> next cycle writeback_control=1, rd=5, writeback_data=0x42; following cycle writeback_control=0.
REQ-020 LB addr 0x1003, dmem_ready after 3 cycles, rdata 0x80FF_FFFF -> stall_m high 3 cycles, then writeback_data=0xFFFF_FF80.
REQ-021 SH addr 0x2002, data 0x1234_ABCD -> dmem_we=1, wstrb=1100, wdata=0xABCD_ABCD, no writeback pulse.
REQ-022 LW addr 0x3001 -> no dmem_req, mem_err pulse, writeback_control=0.
REQ-023 MEM_WB_TIMEOUT_EN, MAX_WAIT=4, dmem_ready never -> dmem_req drops after 4 ACCESS cycles, mem_err pulse, stall_m falls; undefined -> stall_m stays high.
REQ-024 reset_n low 2 cycles mid-ACCESS of LW rd=7 -> dmem_req=0 immediately, no writeback to rd=7 after release.
